// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU-control decode and EX operand selection.
// Optional macro FORWARDING_EN enables EX/MEM and MEM/WB operand forwarding.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_aluop,
  input  logic [5:0]        id_funct,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              exm_regwrite,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_regwrite,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_illegal
);

  logic              valid_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] wreg_q;
  logic              alusrc_q;
  logic              regwrite_q;
  logic              memread_q;
  logic              memwrite_q;
  logic [3:0]        ctrl_q;
  logic              illegal_q;

  logic [3:0]        dec_ctrl;
  logic              dec_illegal;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  always_comb begin
    dec_ctrl    = 4'b0000;
    dec_illegal = 1'b0;
    case (id_aluop)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b11: dec_ctrl = 4'b0001;
      default: begin
        case (id_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          6'b100111: dec_ctrl = 4'b1100;
          default:   dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Priority per edge: flush (bubble) > stall (hold) > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wreg_q     <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      ctrl_q     <= 4'b0000;
      illegal_q  <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wreg_q     <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      ctrl_q     <= 4'b0000;
      illegal_q  <= 1'b0;
    end else if (!stall) begin
      valid_q    <= id_valid;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= id_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      wreg_q     <= id_regdst ? id_rd : id_rt;
      alusrc_q   <= id_alusrc;
      // An empty slot or an unsupported funct must never write the register file.
      regwrite_q <= id_valid & id_regwrite & ~dec_illegal;
      memread_q  <= id_valid & id_memread;
      memwrite_q <= id_valid & id_memwrite;
      ctrl_q     <= dec_ctrl;
      illegal_q  <= dec_illegal;
    end
  end

`ifdef FORWARDING_EN
  // EX/MEM is the younger producer, so it is checked first; r0 is hard-wired zero.
  assign op_a = (exm_regwrite && (exm_rd == rs_q) && (rs_q != '0)) ? exm_result :
                (mwb_regwrite && (mwb_rd == rs_q) && (rs_q != '0)) ? mwb_result :
                rs_data_q;
  assign op_b = (exm_regwrite && (exm_rd == rt_q) && (rt_q != '0)) ? exm_result :
                (mwb_regwrite && (mwb_rd == rt_q) && (rt_q != '0)) ? mwb_result :
                rt_data_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_result,
                        rs_q, rt_q};
  assign op_a = rs_data_q;
  assign op_b = rt_data_q;
`endif

  assign ex_valid      = valid_q;
  assign alu_in1       = op_a;
  assign alu_in2       = alusrc_q ? imm_q : op_b;
  assign alu_ctrl      = ctrl_q;
  assign ex_store_data = op_b;
  assign ex_wreg       = wreg_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [1:0]    id_aluop;
  logic [5:0]    id_funct;
  logic          id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite;
  logic          exm_regwrite, mwb_regwrite;
  logic [AW-1:0] exm_rd, mwb_rd;
  logic [DW-1:0] exm_result, mwb_result;
  logic          ex_valid;
  logic [DW-1:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]    alu_ctrl;
  logic [AW-1:0] ex_wreg;
  logic          ex_regwrite, ex_memread, ex_memwrite, ex_illegal;

  int n_pass  = 0;
  int n_total = 0;

  id_ex_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop), .id_funct(id_funct),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          v;
    logic [3:0]    ctrl;
    logic          ill;
    logic [AW-1:0] wreg, rs, rt;
    logic          rw, mr, mw, alusrc;
    logic [DW-1:0] rsd, rtd, imm;
  } ex_t;

  logic [$bits(ex_t)-1:0] exp_q[$];
  ex_t m;
  logic [3:0] rtype_ctrl [logic [5:0]];
  logic [5:0] legal_funct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};

  initial begin
    rtype_ctrl[6'h20] = 4'h2;  rtype_ctrl[6'h22] = 4'h6;  rtype_ctrl[6'h24] = 4'h0;
    rtype_ctrl[6'h25] = 4'h1;  rtype_ctrl[6'h2a] = 4'h7;  rtype_ctrl[6'h27] = 4'hc;
  end

  function automatic ex_t next_ex();
    ex_t n;
    n = '0;
    n.v = id_valid;
    case (id_aluop)
      2'd0: n.ctrl = 4'h2;
      2'd1: n.ctrl = 4'h6;
      2'd3: n.ctrl = 4'h1;
      default: if (rtype_ctrl.exists(id_funct)) n.ctrl = rtype_ctrl[id_funct];
               else begin n.ctrl = 4'h0; n.ill = 1'b1; end
    endcase
    n.wreg = id_regdst ? id_rd : id_rt;
    n.rs = id_rs;  n.rt = id_rt;
    n.rw = id_valid && id_regwrite && !n.ill;
    n.mr = id_valid && id_memread;
    n.mw = id_valid && id_memwrite;
    n.alusrc = id_alusrc;
    n.rsd = id_rs_data;  n.rtd = id_rt_data;  n.imm = id_imm;
    return n;
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r, input logic [DW-1:0] d);
`ifdef FORWARDING_EN
    if (r != 0 && exm_regwrite && exm_rd == r) return exm_result;
    if (r != 0 && mwb_regwrite && mwb_rd == r) return mwb_result;
`endif
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '0;
      exp_q.delete();
    end else if (flush) begin
      m = '0;
    end else if (!stall) begin
      m = next_ex();
    end
    exp_q.push_back(m);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    ex_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ex_valid", DW'(ex_valid), DW'(e.v));
      check("alu_ctrl", DW'(alu_ctrl), DW'(e.ctrl));
      check("ex_illegal", DW'(ex_illegal), DW'(e.ill));
      check("ex_wreg", DW'(ex_wreg), DW'(e.wreg));
      check("ex_ctrls", DW'({ex_regwrite, ex_memread, ex_memwrite}), DW'({e.rw, e.mr, e.mw}));
      check("alu_in1", alu_in1, fwd(e.rs, e.rsd));
      check("alu_in2", alu_in2, e.alusrc ? e.imm : fwd(e.rt, e.rtd));
      check("ex_store_data", ex_store_data, fwd(e.rt, e.rtd));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_aluop = 0; id_funct = 0;
    id_alusrc = 0; id_regdst = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    exm_regwrite = 0; exm_rd = 0; exm_result = 0;
    mwb_regwrite = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  // One clock: inputs settle before posedge; returns 1ns after the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    set_idle();
    id_valid = 1; id_aluop = 2'b10; id_funct = 6'b100000;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd9; id_regdst = 1; id_regwrite = 1;
    id_rs_data = a; id_rt_data = b;
  endtask

  task automatic drive_random();
    set_idle();
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 9) == 0);
    id_valid = ($urandom_range(0, 5) != 0);
    id_rs_data = $urandom(); id_rt_data = $urandom(); id_imm = $urandom();
    id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
    id_rd = AW'($urandom_range(0, 31));
    id_aluop = 2'($urandom_range(0, 3));
    id_funct = ($urandom_range(0, 3) != 0) ? legal_funct[$urandom_range(0, 5)]
                                           : 6'($urandom_range(0, 63));
    id_alusrc = 1'($urandom()); id_regdst = 1'($urandom()); id_regwrite = 1'($urandom());
    id_memread = 1'($urandom()); id_memwrite = 1'($urandom());
    exm_regwrite = 1'($urandom()); exm_rd = AW'($urandom_range(0, 3)); exm_result = $urandom();
    mwb_regwrite = 1'($urandom()); mwb_rd = AW'($urandom_range(0, 3)); mwb_result = $urandom();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] exp_fwd;
    rst_n = 0;
    set_idle();
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", DW'(ex_valid), 0);
    check("reset_in1", alu_in1, 0);
    check("reset_ctrl", DW'(alu_ctrl), 0);
    rst_n = 1;

    // R-type add.
    drive_add(32'd5, 32'd7);
    tick();
    check("add_ctrl", DW'(alu_ctrl), 32'h2);
    check("add_in1", alu_in1, 32'd5);
    check("add_in2", alu_in2, 32'd7);
    check("add_regwrite", DW'(ex_regwrite), 1);
    check("add_wreg", DW'(ex_wreg), 9);

    // lw: immediate operand, destination is rt.
    set_idle();
    id_valid = 1; id_aluop = 2'b00; id_alusrc = 1; id_imm = 32'hFFFF_FFFC;
    id_rt = 5'd6; id_rd = 5'd12; id_memread = 1; id_regwrite = 1; id_rt_data = 32'h1234;
    tick();
    check("lw_in2", alu_in2, 32'hFFFF_FFFC);
    check("lw_ctrl", DW'(alu_ctrl), 32'h2);
    check("lw_wreg", DW'(ex_wreg), 6);
    check("lw_store", ex_store_data, 32'h1234);

    // Unsupported funct.
    set_idle();
    id_valid = 1; id_aluop = 2'b10; id_funct = 6'b000000; id_regwrite = 1;
    tick();
    check("ill_flag", DW'(ex_illegal), 1);
    check("ill_regwrite", DW'(ex_regwrite), 0);
    check("ill_ctrl", DW'(alu_ctrl), 0);

    // Stall holds for three cycles while ID changes, then flush beats stall.
    drive_add(32'd5, 32'd7);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_random();
      stall = 1; flush = 0; exm_regwrite = 0; mwb_regwrite = 0;
      tick();
      check("stall_in1", alu_in1, 32'd5);
      check("stall_in2", alu_in2, 32'd7);
      check("stall_ctrl", DW'(alu_ctrl), 32'h2);
    end
    stall = 1; flush = 1;
    tick();
    check("flush_valid", DW'(ex_valid), 0);
    check("flush_ctrls", DW'({ex_regwrite, ex_memread, ex_memwrite, alu_ctrl}), 0);
    check("flush_in1", alu_in1, 0);

    // Forwarding: both sources match rs, EX/MEM must win.
    drive_add(32'h11, 32'h22);
    id_rs = 5'd3;
    exm_regwrite = 1; exm_rd = 5'd3; exm_result = 32'hAA;
    mwb_regwrite = 1; mwb_rd = 5'd3; mwb_result = 32'hBB;
    tick();
`ifdef FORWARDING_EN
    exp_fwd = 32'hAA;
`else
    exp_fwd = 32'h11;
`endif
    check("fwd_priority", alu_in1, exp_fwd);
    id_rs = 5'd0; exm_rd = 5'd0; mwb_rd = 5'd0;
    tick();
    check("fwd_r0", alu_in1, 32'h11);

    // Async reset while stalled with live state.
    drive_add(32'd5, 32'd7);
    tick();
    stall = 1;
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", DW'(ex_valid), 0);
    check("async_rst_in1", alu_in1, 0);
    check("async_rst_ctrl", DW'({ex_regwrite, alu_ctrl}), 0);
    @(negedge clk);
    #1 rst_n = 1;

    // Random traffic, checked every cycle by the compare process.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
